// File: rtl/pl_hazard_controller.sv
// pl_hazard_controller
//   Hazard and sequencing control for a five-stage RISC-V pipeline.
//   It produces the Fetch/Decode stall and flush controls, the Execute-stage
//   forwarding selects and a whole-pipeline freeze while data memory is busy.
//   It also runs a post-reset flush sequence, halt/resume, a memory wait
//   timeout and performance counters.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   rs1_D_i, rs2_D_i             Decode-stage source registers
//   rs1_E_i, rs2_E_i, rd_E_i     Execute-stage sources and destination
//   res_src_E_i                  Execute result select (2'b01 = load)
//   jump_i                       taken branch/jump resolved in Execute
//   rd_M_i, rd_W_i               Memory/Writeback destinations
//   reg_wr_M_i, reg_wr_W_i       Memory/Writeback register write enables
//   mem_req_M_i, dmem_ready_i    data memory access and its completion
//   halt_req_i                   level request to pause fetch
//   stall_F_o, stall_D_o         hold the PC / hold the Decode register
//   flush_D_o, flush_E_o         clear Decode / Execute on the next edge
//   freeze_o                     hold Execute/Memory/Writeback, block writes
//   forward_A_src_o, _B_src_o    00 regfile, 01 Writeback, 10 Memory ALU
//   halted_o, mem_err_o          in HALT / sticky wait-timeout flag
//   cycle_cnt_o, stall_cnt_o, flush_cnt_o   performance counters
//
// state | meaning
// INIT  | post-reset bubbles: hold the PC, flush Decode and Execute
// RUN   | normal hazard resolution
// HALT  | Fetch and Decode held, pipeline drains behind Decode
module pl_hazard_controller #(
    parameter int INIT_FLUSH = 2,
    parameter int MAX_WAIT   = 15,
    parameter int CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rs1_D_i,
    input  logic [4:0]       rs2_D_i,
    input  logic [4:0]       rs1_E_i,
    input  logic [4:0]       rs2_E_i,
    input  logic [4:0]       rd_E_i,
    input  logic [1:0]       res_src_E_i,
    input  logic             jump_i,
    input  logic [4:0]       rd_M_i,
    input  logic [4:0]       rd_W_i,
    input  logic             reg_wr_M_i,
    input  logic             reg_wr_W_i,
    input  logic             mem_req_M_i,
    input  logic             dmem_ready_i,
    input  logic             halt_req_i,
    output logic             stall_F_o,
    output logic             stall_D_o,
    output logic             flush_D_o,
    output logic             flush_E_o,
    output logic             freeze_o,
    output logic [1:0]       forward_A_src_o,
    output logic [1:0]       forward_B_src_o,
    output logic             halted_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int IW = (INIT_FLUSH > 1) ? $clog2(INIT_FLUSH) : 1;
    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    init_cnt_q, init_cnt_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q;

    logic stall_mem, load_use, timeout, jump_flush;

    assign stall_mem  = mem_req_M_i && !dmem_ready_i;
    assign load_use   = (res_src_E_i == 2'b01) && (rd_E_i != 5'd0) &&
                        ((rd_E_i == rs1_D_i) || (rd_E_i == rs2_D_i));
    // Only the first timeout matters; once mem_err is set it stays until reset.
    assign timeout    = stall_mem && (wait_cnt_q == WW'(MAX_WAIT)) &&
                        (state_q != INIT) && !mem_err_q;
    assign jump_flush = (state_q == RUN) && !stall_mem && jump_i;

    // Forwarding: the Memory stage holds the younger result, so it wins.
    always_comb begin
        forward_A_src_o = 2'b00;
        forward_B_src_o = 2'b00;
        if (reg_wr_M_i && rd_M_i != 5'd0 && rd_M_i == rs1_E_i)
            forward_A_src_o = 2'b10;
        else if (reg_wr_W_i && rd_W_i != 5'd0 && rd_W_i == rs1_E_i)
            forward_A_src_o = 2'b01;
        if (reg_wr_M_i && rd_M_i != 5'd0 && rd_M_i == rs2_E_i)
            forward_B_src_o = 2'b10;
        else if (reg_wr_W_i && rd_W_i != 5'd0 && rd_W_i == rs2_E_i)
            forward_B_src_o = 2'b01;
    end

    always_comb begin
        stall_F_o = 1'b0;
        stall_D_o = 1'b0;
        flush_D_o = 1'b0;
        flush_E_o = 1'b0;
        freeze_o  = 1'b0;
        case (state_q)
            INIT: begin
                stall_F_o = 1'b1;
                flush_D_o = 1'b1;
                flush_E_o = 1'b1;
            end
            RUN: begin
                if (stall_mem) begin
                    freeze_o  = 1'b1;
                    stall_F_o = 1'b1;
                    stall_D_o = 1'b1;
                end else if (jump_i) begin
                    flush_D_o = 1'b1;
                    flush_E_o = 1'b1;
                end else if (load_use) begin
                    stall_F_o = 1'b1;
                    stall_D_o = 1'b1;
                    flush_E_o = 1'b1;
                end
            end
            HALT: begin
                stall_F_o = 1'b1;
                stall_D_o = 1'b1;
                flush_E_o = 1'b1;
                // After a timeout the memory is presumed dead; let the rest drain.
                freeze_o  = stall_mem && !mem_err_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        mem_err_d  = mem_err_q;
        wait_cnt_d = wait_cnt_q;
        if (state_q == INIT || !stall_mem)
            wait_cnt_d = '0;
        else if (wait_cnt_q != WW'(MAX_WAIT))
            wait_cnt_d = wait_cnt_q + WW'(1);
        case (state_q)
            INIT: begin
                if (init_cnt_q == '0) state_d = RUN;
                else                  init_cnt_d = init_cnt_q - IW'(1);
            end
            RUN: begin
                if (timeout) begin
                    mem_err_d = 1'b1;
                    state_d   = HALT;
                end else if (halt_req_i && !stall_mem && !jump_i && !load_use) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (timeout)                          mem_err_d = 1'b1;
                else if (!halt_req_i && !mem_err_q)   state_d   = RUN;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT;
            init_cnt_q  <= IW'(INIT_FLUSH - 1);
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (state_q == RUN && stall_F_o) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (jump_flush)                  flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign halted_o    = (state_q == HALT);
    assign mem_err_o   = mem_err_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pl_hazard_controller.sv
// Directed bench for pl_hazard_controller with default parameters
// (INIT_FLUSH=2, MAX_WAIT=15, CNT_W=32).
module tb_pl_hazard_controller;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [4:0]  rs1_D_i, rs2_D_i, rs1_E_i, rs2_E_i, rd_E_i, rd_M_i, rd_W_i;
    logic [1:0]  res_src_E_i;
    logic        jump_i, reg_wr_M_i, reg_wr_W_i, mem_req_M_i, dmem_ready_i, halt_req_i;
    logic        stall_F_o, stall_D_o, flush_D_o, flush_E_o, freeze_o, halted_o, mem_err_o;
    logic [1:0]  forward_A_src_o, forward_B_src_o;
    logic [31:0] cycle_cnt_o, stall_cnt_o, flush_cnt_o;

    int errors = 0;
    int checks = 0;
    int ncyc   = 0;

    pl_hazard_controller #(.INIT_FLUSH(2), .MAX_WAIT(15), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rs1_D_i(rs1_D_i), .rs2_D_i(rs2_D_i),
        .rs1_E_i(rs1_E_i), .rs2_E_i(rs2_E_i), .rd_E_i(rd_E_i),
        .res_src_E_i(res_src_E_i), .jump_i(jump_i),
        .rd_M_i(rd_M_i), .rd_W_i(rd_W_i),
        .reg_wr_M_i(reg_wr_M_i), .reg_wr_W_i(reg_wr_W_i),
        .mem_req_M_i(mem_req_M_i), .dmem_ready_i(dmem_ready_i),
        .halt_req_i(halt_req_i),
        .stall_F_o(stall_F_o), .stall_D_o(stall_D_o),
        .flush_D_o(flush_D_o), .flush_E_o(flush_E_o), .freeze_o(freeze_o),
        .forward_A_src_o(forward_A_src_o), .forward_B_src_o(forward_B_src_o),
        .halted_o(halted_o), .mem_err_o(mem_err_o),
        .cycle_cnt_o(cycle_cnt_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk_i);
        if (rst_i) ncyc = 0;
        else       ncyc++;
        #1;
    endtask

    task automatic clear_inputs();
        rs1_D_i = 0; rs2_D_i = 0; rs1_E_i = 0; rs2_E_i = 0; rd_E_i = 0;
        rd_M_i = 0; rd_W_i = 0; res_src_E_i = 0; jump_i = 0;
        reg_wr_M_i = 0; reg_wr_W_i = 0; mem_req_M_i = 0; dmem_ready_i = 0;
        halt_req_i = 0;
    endtask

    initial begin
        clear_inputs();
        rst_i = 1'b1;

        // reset held for three edges
        tick(); tick(); tick();
        chk("rst_stall_F", 64'(stall_F_o), 64'd1);
        chk("rst_flush_D", 64'(flush_D_o), 64'd1);
        chk("rst_flush_E", 64'(flush_E_o), 64'd1);
        chk("rst_stall_D", 64'(stall_D_o), 64'd0);
        chk("rst_freeze", 64'(freeze_o), 64'd0);
        chk("rst_fwdA", 64'(forward_A_src_o), 64'd0);
        chk("rst_halted", 64'(halted_o), 64'd0);
        chk("rst_mem_err", 64'(mem_err_o), 64'd0);
        chk("rst_cycle_cnt", 64'(cycle_cnt_o), 64'd0);
        rst_i = 1'b0;
        #1;
        chk("init1_stall_F", 64'(stall_F_o), 64'd1);

        tick();
        chk("init2_stall_F", 64'(stall_F_o), 64'd1);
        chk("init2_flush_D", 64'(flush_D_o), 64'd1);
        chk("init2_cycle_cnt", 64'(cycle_cnt_o), 64'd1);

        tick();
        chk("run_stall_F", 64'(stall_F_o), 64'd0);
        chk("run_flush_D", 64'(flush_D_o), 64'd0);
        chk("run_flush_E", 64'(flush_E_o), 64'd0);
        chk("run_cycle_cnt", 64'(cycle_cnt_o), 64'd2);

        // forwarding, purely combinational
        rs1_E_i = 5; rd_M_i = 5; reg_wr_M_i = 1; rd_W_i = 5; reg_wr_W_i = 1; #1;
        chk("fwdA_mem", 64'(forward_A_src_o), 64'd2);
        rd_M_i = 0; #1;
        chk("fwdA_wb", 64'(forward_A_src_o), 64'd1);
        rs1_E_i = 0; #1;
        chk("fwdA_x0", 64'(forward_A_src_o), 64'd0);
        rs2_E_i = 9; rd_W_i = 9; rd_M_i = 9; reg_wr_M_i = 0; #1;
        chk("fwdB_wb_only", 64'(forward_B_src_o), 64'd1);
        reg_wr_M_i = 1; #1;
        chk("fwdB_mem", 64'(forward_B_src_o), 64'd2);
        clear_inputs(); #1;

        // load-use
        res_src_E_i = 2'b01; rd_E_i = 7; rs2_D_i = 7; #1;
        chk("lu_stall_F", 64'(stall_F_o), 64'd1);
        chk("lu_stall_D", 64'(stall_D_o), 64'd1);
        chk("lu_flush_E", 64'(flush_E_o), 64'd1);
        chk("lu_flush_D", 64'(flush_D_o), 64'd0);
        tick();
        clear_inputs(); #1;
        chk("lu_stall_cnt", 64'(stall_cnt_o), 64'd1);
        chk("lu_done_stall_F", 64'(stall_F_o), 64'd0);

        // load-use together with a jump: jump wins
        res_src_E_i = 2'b01; rd_E_i = 7; rs2_D_i = 7; jump_i = 1; #1;
        chk("lujmp_flush_D", 64'(flush_D_o), 64'd1);
        chk("lujmp_flush_E", 64'(flush_E_o), 64'd1);
        chk("lujmp_stall_F", 64'(stall_F_o), 64'd0);
        chk("lujmp_stall_D", 64'(stall_D_o), 64'd0);
        tick();
        clear_inputs(); #1;
        chk("lujmp_flush_cnt", 64'(flush_cnt_o), 64'd1);
        chk("lujmp_stall_cnt", 64'(stall_cnt_o), 64'd1);

        // memory wait of three cycles with a jump held throughout
        mem_req_M_i = 1; dmem_ready_i = 0; jump_i = 1; #1;
        for (int i = 0; i < 3; i++) begin
            chk("mw_freeze", 64'(freeze_o), 64'd1);
            chk("mw_flush_D", 64'(flush_D_o), 64'd0);
            chk("mw_stall_D", 64'(stall_D_o), 64'd1);
            tick();
        end
        dmem_ready_i = 1; #1;
        chk("mw_release_freeze", 64'(freeze_o), 64'd0);
        chk("mw_release_flush_D", 64'(flush_D_o), 64'd1);
        tick();
        clear_inputs(); #1;
        chk("mw_flush_cnt", 64'(flush_cnt_o), 64'd2);
        chk("mw_stall_cnt", 64'(stall_cnt_o), 64'd4);

        // halt and resume
        halt_req_i = 1; #1;
        chk("halt_req_halted_pre", 64'(halted_o), 64'd0);
        tick();
        chk("halt_halted", 64'(halted_o), 64'd1);
        chk("halt_stall_F", 64'(stall_F_o), 64'd1);
        chk("halt_stall_D", 64'(stall_D_o), 64'd1);
        chk("halt_flush_E", 64'(flush_E_o), 64'd1);
        chk("halt_flush_D", 64'(flush_D_o), 64'd0);
        halt_req_i = 0;
        tick();
        chk("resume_halted", 64'(halted_o), 64'd0);
        chk("resume_stall_F", 64'(stall_F_o), 64'd0);
        chk("resume_stall_cnt", 64'(stall_cnt_o), 64'd4);

        // wait timeout: 16 stalled cycles
        mem_req_M_i = 1; dmem_ready_i = 0;
        for (int i = 0; i < 15; i++) tick();
        chk("to_15_mem_err", 64'(mem_err_o), 64'd0);
        chk("to_15_halted", 64'(halted_o), 64'd0);
        chk("to_15_freeze", 64'(freeze_o), 64'd1);
        tick();
        chk("to_16_mem_err", 64'(mem_err_o), 64'd1);
        chk("to_16_halted", 64'(halted_o), 64'd1);
        chk("to_16_freeze", 64'(freeze_o), 64'd0);
        chk("to_stall_cnt", 64'(stall_cnt_o), 64'd20);
        clear_inputs();
        tick(); tick();
        chk("to_no_resume", 64'(halted_o), 64'd1);
        chk("to_err_sticky", 64'(mem_err_o), 64'd1);
        chk("cycle_cnt_model", 64'(cycle_cnt_o), 64'(ncyc));

        // reset mid-operation clears everything
        rst_i = 1'b1;
        tick();
        chk("rst2_halted", 64'(halted_o), 64'd0);
        chk("rst2_mem_err", 64'(mem_err_o), 64'd0);
        chk("rst2_cycle_cnt", 64'(cycle_cnt_o), 64'd0);
        chk("rst2_stall_cnt", 64'(stall_cnt_o), 64'd0);
        chk("rst2_flush_cnt", 64'(flush_cnt_o), 64'd0);
        chk("rst2_stall_F", 64'(stall_F_o), 64'd1);
        rst_i = 1'b0;
        tick();
        chk("rst2_cycle_cnt_1", 64'(cycle_cnt_o), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
